// File: rtl/requant_pkg.sv
// requant_pkg: shared constants, types and arithmetic helpers for the
// requantization datapath.
//   ACC_W / OUT_W / SHIFT_W / PROD_W : datapath widths
//   requant_cfg_t                    : per-layer config (mult, shift, zp, relu)
//   s1_t / s2_t                      : payloads carried by pipeline stages 1 and 2
//   round_shr                        : rounding arithmetic right shift (half -> +inf)
//   sat_s8                           : clamp of a wide value into signed int8
package requant_pkg;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 6;
    localparam int MULT_W  = 32;
    localparam int PROD_W  = 64;

    localparam logic signed [OUT_W-1:0] OUT_MAX = 8'sh7f;
    localparam logic signed [OUT_W-1:0] OUT_MIN = 8'sh80;

    typedef struct packed {
        logic signed [MULT_W-1:0] mult;
        logic [SHIFT_W-1:0]       shift;
        logic signed [OUT_W-1:0]  zp;
        logic                     relu;
    } requant_cfg_t;

    localparam requant_cfg_t CFG_RESET = '{mult: 32'sd1, shift: '0, zp: '0, relu: 1'b0};

    // Stage 1 carries the config snapshot taken at acceptance so later
    // stages never look at the live config registers.
    typedef struct packed {
        logic signed [PROD_W-1:0] prod;
        logic [SHIFT_W-1:0]       shift;
        logic signed [OUT_W-1:0]  zp;
        logic                     relu;
    } s1_t;

    typedef struct packed {
        logic signed [PROD_W:0]  r;
        logic signed [OUT_W-1:0] zp;
        logic                    relu;
    } s2_t;

    // One extra bit of headroom: prod + 2^(shift-1) cannot overflow.
    function automatic logic signed [PROD_W:0] round_shr(
        input logic signed [PROD_W-1:0] prod,
        input logic [SHIFT_W-1:0]       shift
    );
        logic signed [PROD_W:0] ext;
        logic signed [PROD_W:0] bias;
        ext  = (PROD_W+1)'(prod);
        bias = 65'sd1 <<< (shift - SHIFT_W'(1));
        if (shift == '0) begin
            return ext;
        end
        return (ext + bias) >>> shift;
    endfunction

    // Compares at full width so out-of-range values never wrap.
    function automatic logic signed [OUT_W-1:0] sat_s8(
        input logic signed [PROD_W+1:0] v,
        input logic signed [OUT_W-1:0]  lo
    );
        logic signed [PROD_W+1:0] lo_w;
        logic signed [PROD_W+1:0] hi_w;
        lo_w = (PROD_W+2)'(lo);
        hi_w = (PROD_W+2)'(OUT_MAX);
        if (v > hi_w) begin
            return OUT_MAX;
        end else if (v < lo_w) begin
            return lo;
        end
        return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/requant_if.sv
// requant_if: valid/ready beat channel.
//   valid : beat valid (master -> slave)
//   ready : slave can accept (slave -> master)
//   data  : signed payload of DATA_W bits (master -> slave)
interface requant_if
    import requant_pkg::*;
#(
    parameter int DATA_W = OUT_W
) ();
    logic                     valid;
    logic                     ready;
    logic signed [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/requant_pipe_reg.sv
// requant_pipe_reg: one stallable valid/ready pipeline register.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   valid_i / data_i  : upstream beat
//   ready_o           : stage can take a beat this cycle (combinational)
//   valid_o / data_o  : registered beat towards the next stage
//   ready_i           : next stage can take a beat
module requant_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);
    // The stage moves when it is empty or its content leaves this cycle.
    assign ready_o = !valid_o || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (ready_o) begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= data_i;
            end
        end
    end
endmodule

// File: rtl/requant.sv
// requant: three-stage stallable requantization pipeline.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   in_if  (slave)         : signed ACC_W biased accumulator beats
//   out_if (master)        : signed OUT_W requantized activations
//   cfg_we_i               : config write strobe (ignored while busy_o)
//   cfg_mult_i/shift_i/zp_i/relu_i : per-layer config values
//   busy_o                 : some stage holds a beat (registered)
//   cfg_err_o              : one-cycle pulse after a rejected config write
module requant
    import requant_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    requant_if.slave                in_if,
    requant_if.master               out_if,
    input  logic                    cfg_we_i,
    input  logic signed [31:0]      cfg_mult_i,
    input  logic [SHIFT_W-1:0]      cfg_shift_i,
    input  logic signed [OUT_W-1:0] cfg_zp_i,
    input  logic                    cfg_relu_i,
    output logic                    busy_o,
    output logic                    cfg_err_o
);
    requant_cfg_t cfg_q;
    logic         busy_q;
    logic         cfg_err_q;

    logic vld_p0, vld_p1, vld_p2;
    logic rdy_p0, rdy_p1, rdy_p2;
    logic vld_nxt_p0, vld_nxt_p1, vld_nxt_p2;

    logic signed [ACC_W-1:0] acc_in;
    s1_t                     s1_in, s1_p0;
    s2_t                     s2_in, s2_p1;
    logic signed [PROD_W+1:0] v_sum;
    logic signed [OUT_W-1:0]  lo_bound;
    logic signed [OUT_W-1:0]  y_in, y_p2;

    // Config registers and status. busy tracks the stage valids as they
    // will be after this edge, so it drops together with the last beat.
    assign vld_nxt_p0 = rdy_p0 ? in_if.valid : vld_p0;
    assign vld_nxt_p1 = rdy_p1 ? vld_p0      : vld_p1;
    assign vld_nxt_p2 = rdy_p2 ? vld_p1      : vld_p2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q     <= CFG_RESET;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            busy_q    <= vld_nxt_p0 || vld_nxt_p1 || vld_nxt_p2;
            cfg_err_q <= cfg_we_i && busy_q;
            if (cfg_we_i && !busy_q) begin
                cfg_q <= '{mult: cfg_mult_i, shift: cfg_shift_i, zp: cfg_zp_i, relu: cfg_relu_i};
            end
        end
    end

    assign busy_o    = busy_q;
    assign cfg_err_o = cfg_err_q;

    // Stage 1: full-width product, config snapshot travels with the beat.
    assign acc_in = in_if.data;
    assign s1_in  = '{prod:  PROD_W'(acc_in) * PROD_W'(cfg_q.mult),
                      shift: cfg_q.shift,
                      zp:    cfg_q.zp,
                      relu:  cfg_q.relu};

    requant_pipe_reg #(.DATA_W($bits(s1_t))) u_p0 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (in_if.valid),
        .ready_o (rdy_p0),
        .data_i  (s1_in),
        .valid_o (vld_p0),
        .ready_i (rdy_p1),
        .data_o  (s1_p0)
    );

    assign in_if.ready = rdy_p0;

    // Stage 2: rounding right shift.
    assign s2_in = '{r: round_shr(s1_p0.prod, s1_p0.shift), zp: s1_p0.zp, relu: s1_p0.relu};

    requant_pipe_reg #(.DATA_W($bits(s2_t))) u_p1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (vld_p0),
        .ready_o (rdy_p1),
        .data_i  (s2_in),
        .valid_o (vld_p1),
        .ready_i (rdy_p2),
        .data_o  (s2_p1)
    );

    // Stage 3: zero-point add and clamp. zp is already int8, so
    // max(zp, -128) is zp itself when ReLU is on.
    assign v_sum    = (PROD_W+2)'(s2_p1.r) + (PROD_W+2)'(s2_p1.zp);
    assign lo_bound = s2_p1.relu ? s2_p1.zp : OUT_MIN;
    assign y_in     = sat_s8(v_sum, lo_bound);

    requant_pipe_reg #(.DATA_W(OUT_W)) u_p2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (vld_p1),
        .ready_o (rdy_p2),
        .data_i  (y_in),
        .valid_o (vld_p2),
        .ready_i (out_if.ready),
        .data_o  (y_p2)
    );

    assign out_if.valid = vld_p2;
    assign out_if.data  = y_p2;

endmodule

// File: doc/requant.md
# requant

Requantization stage directly downstream of the bias adder in the output datapath. Takes one signed 32-bit biased accumulator per beat and multiplies it by a per-layer fixed-point multiplier. Then applies a rounding arithmetic right shift, adds the output zero-point, optionally applies ReLU, and saturates to signed int8. The result goes to the activation write-back. Three-stage, fully stallable pipeline with valid/ready on both sides; throughput one beat per cycle.

## Interface
Parameters:
- ACC_W, 32, input accumulator width (signed)
- OUT_W, 8, output width (signed)
- SHIFT_W, 6, shift-amount width

Ports (reset is asynchronous, active-low; single clock domain):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  stage can accept input
- data_i  in  ACC_W  signed biased accumulator
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream accepts output
- data_o  out  OUT_W  signed requantized activation
- cfg_we_i  in  1  config write strobe
- cfg_mult_i  in  32  signed multiplier
- cfg_shift_i  in  SHIFT_W  right-shift amount, 0..63
- cfg_zp_i  in  OUT_W  signed output zero-point
- cfg_relu_i  in  1  ReLU enable
- busy_o  out  1  any pipeline stage holds a valid beat
- cfg_err_o  out  1  one-cycle pulse: config write rejected

## Operation
- Config registers:
  - Reset values: mult=1, shift=0, zp=0, relu=0.
  - cfg_we_i with busy_o=0 loads all four registers at the clock edge.
  - cfg_we_i with busy_o=1 changes nothing and pulses cfg_err_o the next cycle.
- S1: prod = data_i * mult, full 64-bit signed product.
- S2: rounding shift, half rounds toward +inf.
  - shift=0: r = prod.
  - Otherwise r = (prod + 2^(shift-1)) >>> shift.
  - Computed in 65 bits, so the rounding add can never overflow.
- S3:
  - v = r + sign-extended zp.
  - lo = relu ? max(zp, -128) : -128; hi = 127.
  - data_o = clamp(v, lo, hi).
  - Saturation compares the full-width value; no truncation before the clamp.
- Handshake:
  - Input transfer on valid_i && ready_o; output transfer on valid_o && ready_i.
  - Each stage advances when it is empty or its successor advances in the same cycle.
  - ready_o = !s1_valid || s1_advances.
  - data_o is held stable while valid_o && !ready_i.
  - Beats are never dropped or reordered.
- Simultaneous input accept and output drain in one cycle is legal and keeps full throughput.
- Config registers are only sampled as data enters S1. Each beat is requantized with the config active at its acceptance, and the busy interlock guarantees that config does not change mid-stream.

## Timing
- Latency: 3 cycles from input transfer to valid_o, with ready_i held high.
- Full throughput (1/cycle) with ready_i held high.
- Reset (asynchronous assert, synchronous-safe deassert by the top level):
  - valid_o=0, data_o=0, busy_o=0, cfg_err_o=0.
  - All stage valids cleared; config registers return to reset values.
  - ready_o=1 in the first cycle after release.
- Reset asserted mid-stream discards all in-flight beats; no output pulses follow.
- Backpressure with all three stages full: ready_o falls combinationally in the same cycle ready_i is low, and recovers in the cycle ready_i returns high.
- busy_o is registered from the stage valids. It reads 0 the cycle after the last beat transfers out.

## Structure
- Package requant_pkg holds:
  - ACC_W, OUT_W, SHIFT_W, PROD_W=64 constants.
  - Typedef requant_cfg_t, a packed struct of mult, shift, zp, relu.
  - Functions sat_s8 and round_shr, shared with a future per-channel variant.
- One natural sub-module: pipe_reg, a parameterized-width valid/ready stage register, instantiated three times. The arithmetic lives between the instances in requant.

## Test plan
- Identity saturation: cfg reset values; data 100, 1000, -1000 -> 100, 127, -128.
- Rounding: mult=3, shift=3.
  - data 300 (900/8=112.5) -> 113.
  - data -300 (-112.5) -> -112.
  - data 299 (897/8=112.125) -> 112.
- Zero-point and ReLU: zp=-10, relu=1, mult=1, shift=0.
  - data -50 -> -10.
  - data 20 -> 10.
  - With relu=0, data -50 -> -60.
- Backpressure: stream 6 beats (1..6, identity cfg).
  - ready_i is held low cycles 2-6.
  - ready_o falls once 3 beats are buffered.
  - The output sequence is exactly 1..6 with data_o stable while stalled.
- Config interlock: cfg_we_i (mult=2) while busy_o=1.
  - cfg_err_o pulses; in-flight and subsequent beats use mult=1.
  - Writing again after busy_o=0 takes effect: data 5 -> 10.
- Reset mid-stream: assert rst_ni with 3 beats in flight.
  - valid_o=0 immediately; after release no stale beat appears.
  - The next input 7 -> 7 after 3 cycles.
